// File: rtl/alu_pipe_param_if.sv
// Operand/result handshake bundle for alu_pipe_param.
// The master supplies operands and accepts results; the slave is the ALU.
interface alu_pipe_param_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_hi;
   logic             ach;
   logic             zero;
   logic             neg;
   logic             ovf;
   logic             err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, res, res_hi, ach, zero, neg, ovf, err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, res, res_hi, ach, zero, neg, ovf, err
   );
endinterface

// File: rtl/alu_pipe_param.sv
// Parametrised handshaked ALU: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide (one bit per cycle).
module alu_pipe_param #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic            clk,
   input logic            rst,
   input logic            en,
   alu_pipe_param_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [SHW-1:0]   count_q, count_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             ach_q, ach_d, zero_q, zero_d, neg_q, neg_d;
   logic             ovf_q, ovf_d, err_q, err_d;

   logic             in_ready_w, accept_w;
   logic [WIDTH:0]   sum_w, diff_w;
   logic [SHW-1:0]   sh_w;
   logic [WIDTH-1:0] alu_res, alu_hi;
   logic             alu_ach, alu_ovf, alu_err, alu_multi;

   // Single-cycle result computed straight from the presented operands.
   always_comb begin
      sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
      diff_w    = {1'b0, bus.a} - {1'b0, bus.b};
      sh_w      = bus.b[SHW-1:0];
      alu_res   = '0;
      alu_hi    = '0;
      alu_ach   = 1'b0;
      alu_ovf   = 1'b0;
      alu_err   = 1'b0;
      alu_multi = 1'b0;
      case (bus.op)
         4'b0000: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_ach = sum_w[WIDTH];
            alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'b0001: begin
            alu_res = diff_w[WIDTH-1:0];
            alu_ach = diff_w[WIDTH];
            alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'b0010: alu_res = bus.a & bus.b;
         4'b0011: alu_res = bus.a | bus.b;
         4'b0100: alu_res = bus.a ^ bus.b;
         4'b0101: alu_res = ~bus.a;
         4'b0110: alu_res = bus.a << sh_w;
         4'b0111: alu_res = bus.a >> sh_w;
         4'b1000: alu_res = $unsigned($signed(bus.a) >>> sh_w);
         4'b1001: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         4'b1010: alu_multi = (bus.b != '0);
         4'b1011: begin
            if (bus.b == '0) begin
               alu_res = '1;
               alu_hi  = bus.a;
               alu_err = 1'b1;
            end else begin
               alu_multi = 1'b1;
            end
         end
         default: alu_err = 1'b1;
      endcase
   end

   // One iteration of each engine; hi/lo hold product or remainder/quotient.
   logic [WIDTH:0]   mul_sum, div_sh, div_trial;
   logic [WIDTH-1:0] mul_hi, mul_lo, div_rem, div_quo;
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
      div_sh    = {hi_q, lo_q[WIDTH-1]};
      div_trial = div_sh - {1'b0, m_q};
      div_rem   = div_trial[WIDTH] ? div_sh[WIDTH-1:0] : div_trial[WIDTH-1:0];
      div_quo   = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
   end

   assign in_ready_w = en && !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
   assign accept_w   = bus.in_valid && in_ready_w;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      m_d      = m_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      ach_d    = ach_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         CALC: begin
            count_d = count_q + 1'b1;
            hi_d    = is_div_q ? div_rem : mul_hi;
            lo_d    = is_div_q ? div_quo : mul_lo;
            if (count_q == LAST) begin
               state_d  = DONE;
               res_d    = is_div_q ? div_quo : mul_lo;
               res_hi_d = is_div_q ? div_rem : mul_hi;
               ach_d    = !is_div_q && (mul_hi != '0);
               zero_d   = (is_div_q ? div_quo : mul_lo) == '0;
               neg_d    = is_div_q ? div_quo[WIDTH-1] : mul_lo[WIDTH-1];
               ovf_d    = 1'b0;
               err_d    = 1'b0;
            end
         end
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: ;
      endcase
      // Acceptance is only possible in IDLE or in DONE while draining.
      if (accept_w) begin
         if (alu_multi) begin
            state_d  = CALC;
            count_d  = '0;
            is_div_d = bus.op[0];
            m_d      = bus.op[0] ? bus.b : bus.a;
            hi_d     = '0;
            lo_d     = bus.op[0] ? bus.a : bus.b;
         end else begin
            state_d  = DONE;
            res_d    = alu_res;
            res_hi_d = alu_hi;
            ach_d    = alu_ach;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            ovf_d    = alu_ovf;
            err_d    = alu_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         res_q    <= '0;
         res_hi_q <= '0;
         ach_q    <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         m_q      <= m_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         ach_q    <= ach_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == DONE);
   assign bus.res       = res_q;
   assign bus.res_hi    = res_hi_q;
   assign bus.ach       = ach_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
   assign bus.ovf       = ovf_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param (WIDTH=32): directed vectors pushed on
// issue, popped and compared by a monitor on every output transfer.
module tb_alu_pipe_param;
   typedef struct packed {
      logic [31:0] res;
      logic [31:0] hi;
      logic        ach;
      logic        zero;
      logic        neg;
      logic        ovf;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   run_len = 0;
   int   max_run = 0;
   bit   mon_on = 1'b0;
   exp_t sb[$];

   alu_pipe_param_if #(.WIDTH(32)) bus ();
   alu_pipe_param #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                               input logic ach, input logic ovf, input logic err);
      exp_t e;
      e.res = r; e.hi = h; e.ach = ach; e.ovf = ovf; e.err = err;
      e.zero = (r == 32'h0);
      e.neg  = r[31];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Present an op and hold it until accepted; returns just after the accept edge.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] top,
                       input exp_t e, input bit push);
      int w = 0;
      bus.a = ta; bus.b = tb_; bus.op = top; bus.in_valid = 1'b1;
      if (push) sb.push_back(e);
      @(negedge clk);
      while (!bus.in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts cycles from acceptance to out_valid; in_ready must stay low meanwhile.
   task automatic lat_check(input string nm, input int exp_lat);
      int lat = 1;
      bit rdy_seen = 1'b0;
      while (lat < 100) begin
         @(negedge clk);
         if (bus.out_valid) break;
         if (bus.in_ready) rdy_seen = 1'b1;
         @(posedge clk);
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      if (exp_lat > 1) chk({nm, "_in_ready_calc"}, 64'(rdy_seen), 64'd0);
      step();
   endtask

   task automatic run(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic [3:0] top, input exp_t e, input int exp_lat);
      send(ta, tb_, top, e, 1'b1);
      lat_check(nm, exp_lat);
   endtask

   // Monitor: pops and compares on each output transfer.
   initial begin
      exp_t e;
      int   n = 0;
      wait (mon_on);
      forever begin
         @(negedge clk);
         if (rst || !bus.out_valid) begin
            run_len = 0;
         end else begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (bus.out_ready) begin
               n++;
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("[TB] FAIL unexpected_result: got res=0x%08h, expected no output", bus.res);
               end else begin
                  e = sb.pop_front();
                  if ({bus.res, bus.res_hi, bus.ach, bus.zero, bus.neg, bus.ovf, bus.err} !== e) begin
                     fails++;
                     $display("[TB] FAIL txn%0d: got res=0x%08h hi=0x%08h ach/zero/neg/ovf/err=%b%b%b%b%b, expected res=0x%08h hi=0x%08h flags=%b%b%b%b%b",
                              n, bus.res, bus.res_hi, bus.ach, bus.zero, bus.neg, bus.ovf, bus.err,
                              e.res, e.hi, e.ach, e.zero, e.neg, e.ovf, e.err);
                  end else begin
                     $display("[TB] txn%0d res=0x%08h hi=0x%08h flags=%b%b%b%b%b ok",
                              n, bus.res, bus.res_hi, bus.ach, bus.zero, bus.neg, bus.ovf, bus.err);
                  end
               end
            end
         end
      end
   end

   initial begin
      int w;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
      chk("reset_res", {bus.res, bus.res_hi}, 64'd0);
      chk("reset_flags", 64'({bus.ach, bus.zero, bus.neg, bus.ovf, bus.err}), 64'd0);
      rst = 1'b0;
      mon_on = 1'b1;
      step();
      chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

      run("add",      32'h000000FF, 32'h0000000F, 4'b0000, mk(32'h0000010E, 0, 0, 0, 0), 1);
      run("sub",      32'h000000FF, 32'h0000000F, 4'b0001, mk(32'h000000F0, 0, 0, 0, 0), 1);
      run("add_ovf",  32'h7FFFFFFF, 32'h00000001, 4'b0000, mk(32'h80000000, 0, 0, 1, 0), 1);
      run("sub_brw",  32'h00000000, 32'h00000001, 4'b0001, mk(32'hFFFFFFFF, 0, 1, 0, 0), 1);
      run("or",       32'hF0000000, 32'h0000000F, 4'b0011, mk(32'hF000000F, 0, 0, 0, 0), 1);
      run("not",      32'h00000000, 32'h12345678, 4'b0101, mk(32'hFFFFFFFF, 0, 0, 0, 0), 1);
      run("shl",      32'h00000001, 32'h00000004, 4'b0110, mk(32'h00000010, 0, 0, 0, 0), 1);
      run("shl0",     32'h0000ABCD, 32'h00000020, 4'b0110, mk(32'h0000ABCD, 0, 0, 0, 0), 1);
      run("shr",      32'h80000000, 32'h0000001F, 4'b0111, mk(32'h00000001, 0, 0, 0, 0), 1);
      run("sra",      32'h80000000, 32'h00000004, 4'b1000, mk(32'hF8000000, 0, 0, 0, 0), 1);
      run("slt_t",    32'hFFFFFFFF, 32'h00000001, 4'b1001, mk(32'h00000001, 0, 0, 0, 0), 1);
      run("slt_f",    32'h00000001, 32'hFFFFFFFF, 4'b1001, mk(32'h00000000, 0, 0, 0, 0), 1);
      run("mul",      32'hFFFFFFFF, 32'h00000002, 4'b1010, mk(32'hFFFFFFFE, 32'h1, 1, 0, 0), 33);
      run("mul_small",32'h00000003, 32'h00000005, 4'b1010, mk(32'h0000000F, 0, 0, 0, 0), 33);
      run("mul_b0",   32'h12345678, 32'h00000000, 4'b1010, mk(32'h00000000, 0, 0, 0, 0), 1);
      run("div",      32'h000000FF, 32'h0000000F, 4'b1011, mk(32'h00000011, 0, 0, 0, 0), 33);
      run("div0",     32'h00000005, 32'h00000000, 4'b1011, mk(32'hFFFFFFFF, 32'h5, 0, 0, 1), 1);
      run("illegal",  32'h12345678, 32'h9ABCDEF0, 4'b1111, mk(32'h00000000, 0, 0, 0, 1), 1);

      // Backpressure: AND result held for 5 cycles, then drained alongside a new XOR.
      bus.out_ready = 1'b0;
      send(32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, mk(32'hF000F000, 0, 0, 0, 0), 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {bus.res, 27'd0, bus.out_valid, bus.in_ready, bus.zero, bus.neg, bus.err},
             {32'hF000F000, 27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
         step();
      end
      bus.out_ready = 1'b1;
      send(32'h12345678, 32'hFFFFFFFF, 4'b0100, mk(32'hEDCBA987, 0, 0, 0, 0), 1'b1);
      @(negedge clk);
      chk("xor_next_cycle", {31'd0, bus.out_valid, bus.res}, {31'd0, 1'b1, 32'hEDCBA987});
      step();
      step();

      // Throughput: 8 back-to-back ADDs.
      max_run = 0;
      for (int i = 0; i < 8; i++)
         send(32'(i), 32'(2 * i), 4'b0000, mk(32'(3 * i), 0, 0, 0, 0), 1'b1);
      repeat (3) step();
      chk("stream_run", 64'(max_run), 64'd8);

      // en low blocks acceptance.
      en = 1'b0;
      bus.a = 32'h1; bus.b = 32'h1; bus.op = 4'b0000; bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("en0_in_ready", 64'(bus.in_ready), 64'd0);
         step();
      end
      bus.in_valid = 1'b0;
      en = 1'b1;
      step();

      // en dropped during CALC does not stall the divider.
      send(32'd100, 32'd7, 4'b1011, mk(32'h0000000E, 32'h2, 0, 0, 0), 1'b1);
      en = 1'b0;
      lat_check("div_en0", 33);
      en = 1'b1;
      step();

      // Reset in the middle of a MUL: no result, outputs cleared.
      send(32'h00000007, 32'h00000009, 4'b1010, mk(32'd63, 0, 0, 0, 0), 1'b0);
      repeat (9) step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_mid_res", {bus.res, bus.res_hi}, 64'd0);
      chk("rst_mid_flags", 64'({bus.ach, bus.zero, bus.neg, bus.ovf, bus.err}), 64'd0);
      rst = 1'b0;
      repeat (40) step();
      @(negedge clk);
      chk("rst_mid_idle_ready", 64'(bus.in_ready), 64'd1);

      w = 0;
      while (sb.size() != 0 && w < 200) begin
         step();
         w++;
      end
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
